// File: rtl/bbw_bus_arbiter_pkg.sv
// Shared types, default parameters and width helpers for the BBW pad arbiter.
package bbw_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int unsigned DEF_NREQ     = 4;
  localparam int unsigned DEF_TURN_CYC = 2;
  localparam int unsigned DEF_MAX_HOLD = 16;

  // Bits needed to index n values, never less than one.
  function automatic int unsigned width_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned REQ_W  = width_for(DEF_NREQ);
  localparam int unsigned HOLD_W = width_for(DEF_MAX_HOLD + 1);
  localparam int unsigned TURN_W = width_for(DEF_TURN_CYC + 1);

endpackage

// File: rtl/bbw_bus_arbiter_rr_pick.sv
// Rotating-priority picker: first set request scanning from base upward, wrapping.
module bbw_bus_arbiter_rr_pick
  import bbw_bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned IDX_W = width_for(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] base,
  output logic [NREQ-1:0]  onehot_c,
  output logic             valid_c,
  output logic [IDX_W-1:0] index_c
);

  logic [IDX_W-1:0] cand;

  // Scan candidates base, base+1, ... mod NREQ and keep the first hit.
  always_comb begin
    onehot_c = '0;
    valid_c  = 1'b0;
    index_c  = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDX_W'((32'(base) + i) % NREQ);
      if (!valid_c && req[cand]) begin
        valid_c        = 1'b1;
        index_c        = cand;
        onehot_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bbw_bus_arbiter.sv
// Round-robin owner scheduler for a shared BBW bus-keeper pad with turnaround and loopback check.
module bbw_bus_arbiter
  import bbw_bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = DEF_NREQ,
  parameter int unsigned TURN_CYC = DEF_TURN_CYC,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] TXD,
  output logic [NREQ-1:0] GNT,
  output logic            PAD_I,
  output logic            PAD_T,
  input  logic            PAD_O,
  output logic            RXD,
  output logic            BUSY,
  output logic            LB_ERR
);

  localparam int unsigned REQ_BITS  = width_for(NREQ);
  localparam int unsigned HOLD_BITS = width_for(MAX_HOLD + 1);
  localparam int unsigned TURN_BITS = width_for(TURN_CYC + 1);

  state_t                state, state_nxt;
  logic [NREQ-1:0]       gnt_nxt;
  logic                  pad_i_nxt, pad_t_nxt;
  logic [REQ_BITS-1:0]   rr_ptr, rr_nxt;
  logic [REQ_BITS-1:0]   owner, owner_nxt;
  logic [HOLD_BITS-1:0]  hold_cnt, hold_nxt;
  logic [TURN_BITS-1:0]  turn_cnt, turn_nxt;
  logic                  do_arb;
  logic                  drv_d;

  logic [NREQ-1:0]       pick_onehot;
  logic                  pick_valid;
  logic [REQ_BITS-1:0]   pick_idx;

  bbw_bus_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (REQ_BITS)
  ) u_pick (
    .req      (REQ),
    .base     (rr_ptr),
    .onehot_c (pick_onehot),
    .valid_c  (pick_valid),
    .index_c  (pick_idx)
  );

  // Next-state and next-output logic for the IDLE/DRIVE/TURN sequencer.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = GNT;
    pad_i_nxt = PAD_I;
    pad_t_nxt = PAD_T;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    hold_nxt  = hold_cnt;
    turn_nxt  = turn_cnt;
    do_arb    = 1'b0;

    case (state)
      IDLE: do_arb = 1'b1;
      DRIVE: begin
        // Release on request drop or hold expiry; both take the same single exit.
        if (!REQ[owner] || (hold_cnt == HOLD_BITS'(MAX_HOLD - 1))) begin
          state_nxt = TURN;
          gnt_nxt   = '0;
          pad_t_nxt = 1'b1;
          pad_i_nxt = 1'b0;
          rr_nxt    = REQ_BITS'((32'(owner) + 1) % NREQ);
          turn_nxt  = '0;
        end else begin
          pad_i_nxt = TXD[owner];
          hold_nxt  = hold_cnt + HOLD_BITS'(1);
        end
      end
      TURN: begin
        if (turn_cnt == TURN_BITS'(TURN_CYC - 1)) begin
          do_arb = 1'b1;
        end else begin
          turn_nxt = turn_cnt + TURN_BITS'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        pad_t_nxt = 1'b1;
        pad_i_nxt = 1'b0;
      end
    endcase

    // Hand the pad to the round-robin winner, or park in IDLE with the pad released.
    if (do_arb) begin
      if (pick_valid) begin
        state_nxt = DRIVE;
        gnt_nxt   = pick_onehot;
        pad_t_nxt = 1'b0;
        pad_i_nxt = TXD[pick_idx];
        owner_nxt = pick_idx;
        hold_nxt  = '0;
      end else begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        pad_t_nxt = 1'b1;
        pad_i_nxt = 1'b0;
      end
    end
  end

  // State, counters, pad controls and loopback registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      GNT      <= '0;
      PAD_I    <= 1'b0;
      PAD_T    <= 1'b1;
      rr_ptr   <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      BUSY     <= 1'b0;
      RXD      <= 1'b0;
      drv_d    <= 1'b0;
      LB_ERR   <= 1'b0;
    end else begin
      state    <= state_nxt;
      GNT      <= gnt_nxt;
      PAD_I    <= pad_i_nxt;
      PAD_T    <= pad_t_nxt;
      rr_ptr   <= rr_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      turn_cnt <= turn_nxt;
      BUSY     <= (state_nxt != IDLE);
      RXD      <= PAD_O;
      drv_d    <= (state == DRIVE);
      // Flag a readback mismatch only when this and the previous cycle both drove,
      // so the first driven bit is allowed to settle.
      LB_ERR   <= (state == DRIVE) && drv_d && (PAD_O != PAD_I);
    end
  end

endmodule

// File: tb/tb_bbw_bus_arbiter.sv
// Self-checking bench for bbw_bus_arbiter: vector table plus multi-cycle corner sequences.
module tb_bbw_bus_arbiter;

  typedef struct {
    logic [3:0] gnt;
    logic       pad_t;
    logic       pad_i;
    logic       busy;
    logic       lb_err;
    logic       rxd;
    bit         chk_rxd;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] txd;
    exp_t       e;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] REQ = '0;
  logic [3:0] TXD = '0;
  logic [3:0] GNT;
  logic       PAD_I, PAD_T, PAD_O, RXD, BUSY, LB_ERR;
  logic       keep = 1'b0;
  logic       force_en = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tv[12];

  bbw_bus_arbiter #(.NREQ(4), .TURN_CYC(2), .MAX_HOLD(16)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .TXD    (TXD),
    .GNT    (GNT),
    .PAD_I  (PAD_I),
    .PAD_T  (PAD_T),
    .PAD_O  (PAD_O),
    .RXD    (RXD),
    .BUSY   (BUSY),
    .LB_ERR (LB_ERR)
  );

  always #5 CLK = ~CLK;

  // Pad model: driven value when enabled, keeper level when high-Z, optional stuck-at-0.
  assign PAD_O = force_en ? 1'b0 : (PAD_T ? keep : PAD_I);
  always @(posedge CLK) if (!PAD_T) keep <= PAD_O;

  function automatic exp_t mk(input logic [3:0] g, input logic t, input logic i,
                              input logic b, input logic lb, input logic r, input bit cr);
    exp_t e;
    e.gnt = g; e.pad_t = t; e.pad_i = i; e.busy = b; e.lb_err = lb; e.rxd = r; e.chk_rxd = cr;
    return e;
  endfunction

  function automatic vec_t mv(input logic [3:0] req, input logic [3:0] txd, input logic [3:0] g,
                              input logic t, input logic i, input logic b, input logic r);
    vec_t v;
    v.req = req; v.txd = txd; v.e = mk(g, t, i, b, 1'b0, r, 1'b1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, then compare after the edge.
  task automatic cyc(input logic [3:0] req, input logic [3:0] txd, input exp_t e, input string tag);
    exp_t x;
    REQ = req;
    TXD = txd;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    x = sb.pop_front();
    chk({tag, ".gnt"},    GNT,               x.gnt);
    chk({tag, ".pad_t"},  {3'b0, PAD_T},     {3'b0, x.pad_t});
    chk({tag, ".pad_i"},  {3'b0, PAD_I},     {3'b0, x.pad_i});
    chk({tag, ".busy"},   {3'b0, BUSY},      {3'b0, x.busy});
    chk({tag, ".lb_err"}, {3'b0, LB_ERR},    {3'b0, x.lb_err});
    chk({tag, ".onehot"}, {3'b0, $onehot0(GNT)}, 4'd1);
    if (x.chk_rxd) chk({tag, ".rxd"}, {3'b0, RXD}, {3'b0, x.rxd});
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cyc(4'b0000, 4'b0000, mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "reset");
    RST = 1'b0;
  endtask

  initial begin
    logic [3:0] t;
    logic [1:0] k;

    // Reset held three cycles with no requests; keeper holds the line low.
    RST = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(4'b0000, 4'b0000, mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "rst_hold");
    RST = 1'b0;

    // Single owner for five cycles, turnaround, idle; then rr_ptr=1 makes requester 1 win over 0.
    tv[0]  = mv(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0);
    tv[1]  = mv(4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1);
    tv[2]  = mv(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0);
    tv[3]  = mv(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1);
    tv[4]  = mv(4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1);
    tv[5]  = mv(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
    tv[6]  = mv(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
    tv[7]  = mv(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tv[8]  = mv(4'b0011, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    tv[9]  = mv(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
    tv[10] = mv(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
    tv[11] = mv(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cyc(tv[i].req, tv[i].txd, tv[i].e, $sformatf("vec%0d", i));

    // All requesting: owners 0,1,2,3,0, each 16 drive cycles then 2 high-Z cycles.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      k = 2'(g % 4);
      for (int c = 0; c < 16; c++) begin
        t = 4'($urandom_range(0, 15));
        cyc(4'b1111, t, mk(4'b0001 << k, 1'b0, t[k], 1'b1, 1'b0, 1'b0, 1'b0),
            $sformatf("rr_own%0d_c%0d", g, c));
      end
      for (int c = 0; c < 2; c++)
        cyc(4'b1111, 4'b0000, mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
            $sformatf("rr_turn%0d_c%0d", g, c));
    end

    // Sole requester held: preempted at MAX_HOLD, regains after turnaround.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      t = 4'($urandom_range(0, 15));
      cyc(4'b0100, t, mk(4'b0100, 1'b0, t[2], 1'b1, 1'b0, 1'b0, 1'b0), $sformatf("hold_c%0d", c));
    end
    for (int c = 0; c < 2; c++)
      cyc(4'b0100, 4'b0100, mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), $sformatf("hold_turn%0d", c));
    cyc(4'b0100, 4'b0100, mk(4'b0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "hold_regain");

    // Reset during drive cycle 3 releases the pad at once and clears rr_ptr.
    do_reset();
    for (int c = 0; c < 3; c++)
      cyc(4'b0001, 4'b0001, mk(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), $sformatf("mid_c%0d", c));
    RST = 1'b1;
    cyc(4'b0001, 4'b0001, mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rst_mid");
    RST = 1'b0;
    cyc(4'b0011, 4'b0001, mk(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "rr_after_rst");

    // Loopback: pad stuck low during drive cycle f; only f>=2 raises LB_ERR, in cycle f+1.
    for (int f = 1; f <= 2; f++) begin
      force_en = 1'b0;
      do_reset();
      for (int c = 1; c <= 6; c++) begin
        cyc(4'b0001, 4'b0001,
            mk(4'b0001, 1'b0, 1'b1, 1'b1, (f >= 2 && c == f + 1), (c - 1 != f), (c > 1)),
            $sformatf("lb_f%0d_c%0d", f, c));
        force_en = (c == f);
      end
      force_en = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
